pes_piso_serializer: RTL and testbench
======================================

// Module: pes_piso_serializer
// PURPOSE
//  Parallel-in serial-out framer that sits directly upstream of pes_siso; serial_out drives pes_siso.serial_in.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk.
//  frame_active marks the valid bit window; last_bit marks the final bit of each word.
//  Optional idle gap between words; GAP_CYCLES=0 gives a continuous back-to-back bit stream.
// PARAMETERS
//  WIDTH       8  bits per word (>=2)
//  MSB_FIRST   1  1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
//  GAP_CYCLES  1  idle cycles (serial_out=0, frame_active=0) after each word (0..15)
// PORTS
//  clk           in   1      single clock; all state updates on posedge
//  reset         in   1      synchronous, active-low: reset==0 at a posedge resets the block
//  data_in       in   WIDTH  parallel word; sampled only on the accept edge
//  data_valid    in   1      upstream has a word on data_in
//  data_ready    out  1      block can accept a word this cycle
//  serial_out    out  1      serial bit stream to pes_siso.serial_in
//  frame_active  out  1      serial_out carries a data bit this cycle
//  last_bit      out  1      serial_out carries the final bit of the current word
// BEHAVIOUR
//  Reset: after any posedge with reset==0 -> state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0,
//   serial_out=0, frame_active=0, last_bit=0. data_ready is forced to 0 while reset==0.
//  States: IDLE, SHIFT, GAP. All outputs come from registers or registered state only, never from data_valid.
//  Accept = data_valid && data_ready at a posedge. On accept, data_in is loaded into shift_reg and bit_cnt=0.
//  IDLE: data_ready=1, serial_out=0, frame_active=0. On accept -> SHIFT.
//  SHIFT: frame_active=1; serial_out = current bit (MSB or LSB of shift_reg according to MSB_FIRST).
//   Each posedge shifts shift_reg by one and increments bit_cnt.
//   last_bit=1 when bit_cnt==WIDTH-1.
//  Latency: accept at edge N -> bit0 visible after edge N (sampled downstream at N+1); bit WIDTH-1 visible after edge N+WIDTH-1.
//  End of word (SHIFT && last_bit), at the next posedge:
//   GAP_CYCLES>0 -> GAP with gap_cnt=0.
//   GAP_CYCLES==0 -> data_ready=1 during the last-bit cycle. Accept at that edge -> stay in SHIFT, load new word, bit0 follows with no bubble.
//     No accept -> IDLE.
//  GAP: serial_out=0, frame_active=0, data_ready=0. Leaves to IDLE after GAP_CYCLES cycles (gap_cnt==GAP_CYCLES-1).
//  data_ready=0 in SHIFT (except the last-bit case above) and in GAP. data_valid in those cycles is ignored; upstream holds the word.
//  data_in changes after the accept edge do not affect the word in flight.
//  Reset mid-frame: the word is discarded; outputs return to reset values at that edge. No partial word resumes.
//  bit_cnt width = $clog2(WIDTH). gap_cnt width = 4. Counters never wrap beyond their terminal values.
// TESTING
//  T1 reset=0 for 3 cycles with data_valid=1 -> data_ready=0, serial_out=0, frame_active=0, no accept; data_ready=1 the cycle after release.
//  T2 defaults, accept 8'hA5 -> serial_out 1,0,1,0,0,1,0,1 over 8 cycles;
//     last_bit only on the 8th; 1 gap cycle; data_ready=1 again on the 10th cycle after accept.
//  T3 MSB_FIRST=0, accept 8'h0F -> serial_out 1,1,1,1,0,0,0,0; MSB_FIRST=1 same word -> 0,0,0,0,1,1,1,1.
//  T4 GAP_CYCLES=0, data_valid held, words 8'hFF then 8'h00 -> frame_active high for 16 contiguous cycles;
//     8 ones then 8 zeros; last_bit on cycles 8 and 16.
//  T5 reset=0 after 3 bits of 8'hC3 -> next edge serial_out=0, frame_active=0;
//     after release, 8'h81 is sent cleanly as 1,0,0,0,0,0,0,1.
//  T6 chain into pes_siso and send 8'hA5 -> the pes_siso output reproduces 1,0,1,0,0,1,0,1 delayed by that stage's depth;
//     data_in toggled mid-frame has no effect.

Source files
------------

// File: rtl/pes_piso_serializer.sv
// Parallel-in serial-out framer: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock with frame/last markers.
module pes_piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             last_bit
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);
  localparam int unsigned   FIRST    = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               serial_q, serial_d;
  logic               frame_q, frame_d;
  logic               last_q, last_d;

  logic [WIDTH-1:0]   shift_adv;
  logic [CW-1:0]      bit_cnt_inc;
  logic               accept;

  // Ready depends only on registered state (and reset), never on data_valid.
  assign data_ready = reset &&
                      ((state_q == ST_IDLE) ||
                       (NO_GAP && (state_q == ST_SHIFT) && last_q));
  assign accept      = data_valid && data_ready;
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  always_comb begin
    if (MSB_FIRST != 0) shift_adv = {shift_q[WIDTH-2:0], 1'b0};
    else                shift_adv = {1'b0, shift_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    serial_d  = 1'b0;
    frame_d   = 1'b0;
    last_d    = 1'b0;

    if (accept) begin
      // Load presents bit 0 on the registered output right after this edge.
      state_d   = ST_SHIFT;
      shift_d   = data_in;
      bit_cnt_d = '0;
      serial_d  = data_in[FIRST];
      frame_d   = 1'b1;
      last_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SHIFT: begin
          if (last_q) begin
            state_d   = NO_GAP ? ST_IDLE : ST_GAP;
            shift_d   = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
          end else begin
            shift_d   = shift_adv;
            bit_cnt_d = bit_cnt_inc;
            serial_d  = shift_adv[FIRST];
            frame_d   = 1'b1;
            last_d    = (bit_cnt_inc == LAST_IDX);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = ST_IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      serial_q  <= 1'b0;
      frame_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      serial_q  <= serial_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
    end
  end

  assign serial_out   = serial_q;
  assign frame_active = frame_q;
  assign last_bit     = last_q;

endmodule

// File: tb/tb_pes_piso_serializer.sv
// Scoreboard bench: instance 0 is MSB-first with one gap cycle, instance 1 is
// LSB-first back-to-back; every accepted word queues its expected bit stream.
module tb_pes_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       dv  [2];
  logic [7:0] din [2];
  logic       rdy [2];
  logic       so  [2];
  logic       fa  [2];
  logic       lb  [2];

  int checks = 0;
  int errors = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  pes_piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) u0 (
    .clk(clk), .reset(rst_n), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .serial_out(so[0]), .frame_active(fa[0]), .last_bit(lb[0])
  );

  pes_piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(rst_n), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .serial_out(so[1]), .frame_active(fa[1]), .last_bit(lb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int i, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, got, exp, $time);
    end
  endtask

  // Reference: word w becomes 8 (bit, last) pairs in transmit order.
  function automatic void push_word(input int i, input logic [7:0] w);
    logic [1:0] item;
    for (int k = 0; k < 8; k++) begin
      item[1] = (i == 0) ? w[7-k] : w[k];
      item[0] = (k == 7);
      if (i == 0) q0.push_back(item);
      else        q1.push_back(item);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (dv[0] && rdy[0]) push_word(0, din[0]);
      if (dv[1] && rdy[1]) push_word(1, din[1]);
    end
  end

  task automatic mon(input int i);
    logic [1:0] e;
    int         sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (!rst_n) check("ready_in_reset", i, {7'd0, rdy[i]}, 8'd0);
    if (fa[i]) begin
      if (sz == 0) begin
        check("unexpected_bit", i, {7'd0, fa[i]}, 8'd0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check("serial_last", i, {6'd0, so[i], lb[i]}, {6'd0, e});
      end
    end else begin
      check("idle_outputs", i, {6'd0, so[i], lb[i]}, 8'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Hold the word until accepted, then scramble data_in to prove it is not re-read.
  task automatic send(input int i, input logic [7:0] w);
    int n;
    din[i] = w;
    dv[i]  = 1'b1;
    n = 0;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL accept_timeout inst%0d: got no ready expected ready within 200", i);
    end
    @(posedge clk);
    #1;
    dv[i]  = 1'b0;
    din[i] = 8'($urandom);
  endtask

  task automatic rand_run(input int i);
    int idle;
    repeat (40) begin
      idle = $urandom_range(0, 3);
      repeat (idle) begin
        @(negedge clk);
        din[i] = 8'($urandom);
      end
      send(i, 8'($urandom));
    end
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    dv[0]  = 1'b1;
    dv[1]  = 1'b1;
    din[0] = 8'hA5;
    din[1] = 8'h0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 0, {7'd0, rdy[0]}, 8'd1);
    check("ready_after_release", 1, {7'd0, rdy[1]}, 8'd1);

    // A5 MSB-first with one gap cycle; 0F LSB-first in parallel.
    fork
      begin
        send(0, 8'hA5);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rdy[0] && n < 40);
        check("ready_return_cycle", 0, 8'(n), 8'd10);
      end
      send(1, 8'h0F);
    join

    // Back-to-back FF then 00 with no bubble on the gapless instance.
    send(1, 8'hFF);
    fork
      send(1, 8'h00);
      begin
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          check("contiguous_frame", 1, {7'd0, fa[1]}, 8'd1);
        end
        @(negedge clk);
        check("frame_end", 1, {7'd0, fa[1]}, 8'd0);
      end
    join

    // Reset in the middle of C3, then a clean 81.
    repeat (3) @(negedge clk);
    send(0, 8'hC3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_frame", 0, {7'd0, fa[0]}, 8'd0);
    check("midframe_reset_serial", 0, {7'd0, so[0]}, 8'd0);
    rst_n = 1'b1;
    send(0, 8'h81);
    repeat (12) @(negedge clk);
    check("drain_81", 0, 8'(q0.size()), 8'd0);

    fork
      rand_run(0);
      rand_run(1);
    join

    repeat (20) @(negedge clk);
    check("final_drain", 0, 8'(q0.size()), 8'd0);
    check("final_drain", 1, 8'(q1.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
